deskew_buffer: RTL and testbench

Output-side counterpart of the 16-lane input skew buffer. Takes the diagonally skewed 128-bit result stream from the bottom edge of the systolic array, where lane i carries row r at beat r+i. Writes each byte lane into its own row slot and emits aligned 128-bit rows on a valid/ready stream to the result writeback path. Holds one frame of up to 32 rows.

---
 rtl/deskew_pkg.sv | 39 +++
 rtl/deskew_mem.sv | 35 +++
 rtl/deskew_buffer.sv | 135 +++++++++++++
 tb/tb_deskew_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/deskew_pkg.sv
// Shared types and helpers for the output-side deskew buffer.
// Lane/slot geometry and the diagonal lane-to-slot mapping.
package deskew_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 6;
  localparam int WORD_W = LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic              ok;
    logic [ADDR_W-1:0] slot;
  } lane_hit_t;

  // Lane i of beat t belongs to row t-i, kept only when 0 <= t-i < r.
  function automatic lane_hit_t lane_slot(
    input cnt_t       t,
    input logic [3:0] i,
    input cnt_t       r
  );
    logic [CNT_W:0] d;
    lane_hit_t      h;
    d      = {1'b0, t} - {3'b000, i};
    h.ok   = !d[CNT_W] && (d[CNT_W-1:0] < r);
    h.slot = d[ADDR_W-1:0];
    return h;
  endfunction

endpackage

// File: rtl/deskew_mem.sv
// Row storage: one byte bank per lane, each with its own write port,
// read back as a whole aligned row through a registered port.
module deskew_mem
  import deskew_pkg::*;
(
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [LANES-1:0]               we,
  input  logic [LANES-1:0][ADDR_W-1:0]   waddr,
  input  logic [LANES-1:0][LANE_W-1:0]   wdata,
  input  logic                           re,
  input  logic [ADDR_W-1:0]              raddr,
  output logic [WORD_W-1:0]              rdata
);

  logic [LANE_W-1:0] bank [LANES][DEPTH];

  always_ff @(posedge CLK) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) bank[i][waddr[i]] <= wdata[i];
    end
  end

  // Only the read register is cleared; bank contents stay stale.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdata <= '0;
    end else if (re) begin
      for (int i = 0; i < LANES; i++) begin
        rdata[i*LANE_W +: LANE_W] <= bank[i][raddr];
      end
    end
  end

endmodule

// File: rtl/deskew_buffer.sv
// Realigns the diagonally skewed result stream into whole rows
// and streams them out on a valid/ready interface.
module deskew_buffer
  import deskew_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_first,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic [CNT_W-1:0]  rows,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  state_t state;
  cnt_t   t;
  cnt_t   r_q;
  cnt_t   rd;
  cnt_t   done;

  logic   legal;
  logic   start;
  logic   beat;
  logic   acc;
  logic   last_beat;
  logic   load;
  logic   fin;
  logic   bad;
  cnt_t   t_cur;
  cnt_t   r_cur;
  cnt_t   span;

  logic [LANES-1:0]             we;
  logic [LANES-1:0][ADDR_W-1:0] waddr;
  lane_hit_t                    hit [LANES];

  assign legal = (rows != '0) && (rows <= cnt_t'(DEPTH));
  assign start = (state == IDLE) && in_valid && in_first && legal;
  assign beat  = (state == FILL) && in_valid;
  assign acc   = start || beat;
  assign t_cur = start ? '0 : t;
  assign r_cur = start ? rows : r_q;
  assign span  = t_cur - cnt_t'(14);

  assign last_beat = beat && (t == r_q + cnt_t'(14));
  assign load = (state != IDLE) && (!out_valid || out_ready)
             && (rd < done);
  assign fin  = (state == DRAIN) && out_valid && out_ready && out_last;

  assign bad = ((state == IDLE) && in_valid && (!in_first || !legal))
            || ((state == FILL) && in_valid && in_first)
            || ((state == DRAIN) && in_valid);

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      hit[i]   = lane_slot(t_cur, 4'(i), r_cur);
      we[i]    = acc && hit[i].ok;
      waddr[i] = hit[i].slot;
    end
  end

  deskew_mem u_mem (
    .CLK   (CLK),
    .RESET (RESET),
    .we    (we),
    .waddr (waddr),
    .wdata (in_data),
    .re    (load),
    .raddr (rd[ADDR_W-1:0]),
    .rdata (out_data)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      t         <= '0;
      r_q       <= '0;
      rd        <= '0;
      done      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (bad) err <= 1'b1;

      // Row r is complete once beat r+15 has landed.
      if (acc && (t_cur >= cnt_t'(15))) begin
        done <= (span > r_cur) ? r_cur : span;
      end

      if (load) begin
        out_valid <= 1'b1;
        out_last  <= (rd == r_q - cnt_t'(1));
        rd        <= rd + cnt_t'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state <= FILL;
            r_q   <= rows;
            t     <= cnt_t'(1);
          end
        end
        FILL: begin
          if (beat) begin
            t <= t + cnt_t'(1);
            if (last_beat) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fin) begin
            state <= IDLE;
            t     <= '0;
            rd    <= '0;
            done  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deskew_buffer.sv
// Scoreboard bench for deskew_buffer: skewed frames in,
// aligned rows checked against an independent row model.
module tb_deskew_buffer;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         in_first = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic [5:0]   rows = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic         err;

  typedef struct {
    logic [127:0] d;
    logic         l;
  } exp_t;

  exp_t         sb [$];
  int           n_chk = 0;
  int           n_err = 0;
  int           run = 0;
  int           peak = 0;
  bit           tog = 1'b0;
  bit           stalled = 1'b0;
  logic [127:0] held = '0;

  deskew_buffer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_first  (in_first),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .rows      (rows),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] beat_word(input int t);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = {4'(t), 4'(i)};
    return w;
  endfunction

  function automatic logic [127:0] row_word(input int r);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = {4'(r + i), 4'(i)};
    return w;
  endfunction

  task automatic do_reset();
    RESET = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    sb.delete();
  endtask

  task automatic drive_frame(
    input int r,
    input int nbeats,
    input int bad_first,
    input bit push
  );
    exp_t e;
    if (push) begin
      for (int k = 0; k < r; k++) begin
        e.d = row_word(k);
        e.l = (k == r - 1);
        sb.push_back(e);
      end
    end
    for (int t = 0; t < nbeats; t++) begin
      in_valid = 1'b1;
      in_first = (t == 0) || (t == bad_first);
      rows     = 6'(r);
      in_data  = beat_word(t);
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 400) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("drain_busy", 128'(busy), 128'(0));
    check("rows_left", 128'(sb.size()), 128'(0));
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      stalled = 1'b0;
      run = 0;
    end else begin
      if (stalled) begin
        check("hold_valid", 128'(out_valid), 128'(1));
        check("hold_data", out_data, held);
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        run++;
        if (run > peak) peak = run;
        if (sb.size() == 0) begin
          check("spurious_row", 128'(out_valid), 128'(0));
        end else begin
          e = sb.pop_front();
          check("row_data", out_data, e.d);
          check("row_last", 128'(out_last), 128'(e.l));
        end
      end else begin
        run = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (tog) out_ready = ~out_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_out_data", out_data, 128'(0));

    // R=4, sink always ready
    peak = 0;
    drive_frame(4, 19, -1, 1'b1);
    wait_idle();
    check("r4_run", 128'(peak), 128'(4));
    check("r4_err", 128'(err), 128'(0));
    check("r4_in_ready", 128'(in_ready), 128'(1));

    // R=32, sink held off until the frame is fully written
    out_ready = 1'b0;
    peak = 0;
    drive_frame(32, 47, -1, 1'b1);
    check("r32_busy", 128'(busy), 128'(1));
    out_ready = 1'b1;
    wait_idle();
    check("r32_no_bubble", 128'(peak), 128'(32));

    // R=8, sink toggling every cycle
    tog = 1'b1;
    drive_frame(8, 23, -1, 1'b1);
    wait_idle();
    tog = 1'b0;
    #1;
    out_ready = 1'b1;

    // rows=0 start is rejected; a later legal frame still works
    in_valid = 1'b1;
    in_first = 1'b1;
    rows = 6'd0;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    check("r0_err", 128'(err), 128'(1));
    check("r0_busy", 128'(busy), 128'(0));
    drive_frame(2, 17, -1, 1'b1);
    wait_idle();
    check("r2_err_sticky", 128'(err), 128'(1));

    // rows=33 is also rejected
    do_reset();
    check("err_cleared", 128'(err), 128'(0));
    in_valid = 1'b1;
    in_first = 1'b1;
    rows = 6'd33;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    check("r33_err", 128'(err), 128'(1));
    check("r33_busy", 128'(busy), 128'(0));

    // stray in_first mid-frame flags err, data unaffected
    do_reset();
    drive_frame(4, 19, 5, 1'b1);
    wait_idle();
    check("midfirst_err", 128'(err), 128'(1));

    // reset mid-frame, then a short frame: no stale rows
    do_reset();
    drive_frame(16, 10, -1, 1'b0);
    do_reset();
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_ready", 128'(in_ready), 128'(1));
    check("mid_rst_err", 128'(err), 128'(0));
    drive_frame(3, 18, -1, 1'b1);
    wait_idle();
    repeat (5) @(posedge CLK);
    #1;
    check("r3_quiet", 128'(out_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
